// File: rtl/conv_encoder_pkg.sv
// Shared definitions for the rate-1/2-per-bit trellis encoder and its
// decoder-side users: widths, default generator masks, FSM encoding and
// the mask-parity helper used to form each code bit.
package conv_encoder_pkg;

    localparam int STATE_W        = 8;
    localparam int PAIR_W         = 2;
    localparam int WIN_W          = STATE_W + PAIR_W;
    localparam int SYM_W_DEF      = 4;
    localparam int STEP_W         = 2;
    localparam int TAIL_STEPS_DEF = 4;

    // Default generator masks over the window {state[7:0], pair[1:0]}
    localparam logic [WIN_W-1:0] G0_DEF = 10'h001;
    localparam logic [WIN_W-1:0] G1_DEF = 10'h002;
    localparam logic [WIN_W-1:0] G2_DEF = 10'h2AD;
    localparam logic [WIN_W-1:0] G3_DEF = 10'h36B;

    typedef logic [STATE_W-1:0]   trellis_state_t;
    typedef logic [SYM_W_DEF-1:0] sym_t;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ENCODE = 2'd1,
        ST_FLUSH  = 2'd2
    } enc_fsm_t;

    // Even parity of the window bits selected by a generator mask
    function automatic logic mask_parity(input logic [WIN_W-1:0] win,
                                         input logic [WIN_W-1:0] gen);
        return ^(win & gen);
    endfunction

    // Input pair for trellis step k: MSB is byte[2k], LSB is byte[2k+1]
    function automatic logic [PAIR_W-1:0] byte_pair(input logic [7:0]        data,
                                                    input logic [STEP_W-1:0] k);
        logic [PAIR_W-1:0] pair;
        case (k)
            2'd0:    pair = {data[0], data[1]};
            2'd1:    pair = {data[2], data[3]};
            2'd2:    pair = {data[4], data[5]};
            2'd3:    pair = {data[6], data[7]};
            default: pair = 2'b00;
        endcase
        return pair;
    endfunction

endpackage

// File: rtl/conv_sym_gen.sv
// Combinational symbol generator: one code bit per generator mask over the
// window {state, pair}. Shared with the decoder's branch-metric path.
module conv_sym_gen
    import conv_encoder_pkg::*;
#(
    parameter int               SYM_W = SYM_W_DEF,
    parameter logic [WIN_W-1:0] G0    = G0_DEF,
    parameter logic [WIN_W-1:0] G1    = G1_DEF,
    parameter logic [WIN_W-1:0] G2    = G2_DEF,
    parameter logic [WIN_W-1:0] G3    = G3_DEF
) (
    input  logic [WIN_W-1:0] i_window,
    output logic [SYM_W-1:0] o_sym
);

    // Map the window to a code symbol, bit j from generator Gj
    always_comb begin
        o_sym    = {SYM_W{1'b0}};
        o_sym[0] = mask_parity(i_window, G0);
        o_sym[1] = mask_parity(i_window, G1);
        o_sym[2] = mask_parity(i_window, G2);
        o_sym[3] = mask_parity(i_window, G3);
    end

endmodule

// File: rtl/conv_encoder.sv
// Transmit-side trellis encoder. Takes bytes over valid/ready, shifts two
// bits per step through an 8-bit state and emits one registered code symbol
// per step; an optional zero-tail flush drives the trellis back to state 0.
module conv_encoder
    import conv_encoder_pkg::*;
#(
    parameter int               SYM_W      = SYM_W_DEF,
    parameter logic [WIN_W-1:0] G0         = G0_DEF,
    parameter logic [WIN_W-1:0] G1         = G1_DEF,
    parameter logic [WIN_W-1:0] G2         = G2_DEF,
    parameter logic [WIN_W-1:0] G3         = G3_DEF,
    parameter int               TAIL_STEPS = TAIL_STEPS_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [7:0]         i_data,
    input  logic               i_data_valid,
    output logic               o_data_ready,
    input  logic               i_flush,
    output logic [SYM_W-1:0]   o_sym,
    output logic               o_sym_valid,
    input  logic               i_sym_ready,
    output logic [STATE_W-1:0] o_state,
    output logic               o_busy,
    output logic               o_flush_done
);

    localparam logic [STEP_W-1:0] LAST_DATA_STEP = 2'd3;
    localparam logic [STEP_W-1:0] LAST_TAIL_STEP = STEP_W'(TAIL_STEPS - 1);

    // Registered state
    enc_fsm_t          r_fsm;
    trellis_state_t    r_state;
    logic [STEP_W-1:0] r_step;
    logic [7:0]        r_byte;
    logic [SYM_W-1:0]  r_sym;
    logic              r_sym_valid;
    logic              r_data_ready;
    logic              r_busy;
    logic              r_flush_done;

    // Next-state values
    enc_fsm_t          w_fsm_nxt;
    trellis_state_t    w_state_nxt;
    logic [STEP_W-1:0] w_step_nxt;
    logic [7:0]        w_byte_nxt;
    logic [SYM_W-1:0]  w_sym_nxt;
    logic              w_sym_valid_nxt;
    logic              w_data_ready_nxt;
    logic              w_busy_nxt;
    logic              w_flush_done_nxt;

    // Datapath
    logic              w_byte_xfer;
    logic              w_sym_xfer;
    logic [PAIR_W-1:0] w_pair;
    logic [WIN_W-1:0]  w_window;
    logic [SYM_W-1:0]  w_sym;
    trellis_state_t    w_state_shift;

    assign w_byte_xfer   = i_data_valid & r_data_ready;
    assign w_sym_xfer    = r_sym_valid & i_sym_ready;
    assign w_window      = {r_state, w_pair};
    assign w_state_shift = {r_state[STATE_W-PAIR_W-1:0], w_pair};

    // Select the input pair for the symbol about to be loaded: the first
    // pair of an incoming byte, the next pair of the held byte, or a tail zero
    always_comb begin
        w_pair = 2'b00;
        case (r_fsm)
            ST_IDLE: begin
                if (w_byte_xfer) begin
                    w_pair = byte_pair(i_data, 2'd0);
                end else begin
                    w_pair = 2'b00;
                end
            end
            ST_ENCODE: w_pair = byte_pair(r_byte, r_step + 2'd1);
            ST_FLUSH:  w_pair = 2'b00;
            default:   w_pair = 2'b00;
        endcase
    end

    conv_sym_gen #(
        .SYM_W (SYM_W),
        .G0    (G0),
        .G1    (G1),
        .G2    (G2),
        .G3    (G3)
    ) u_sym_gen (
        .i_window (w_window),
        .o_sym    (w_sym)
    );

    // Next-state logic: a new symbol (and the matching state shift) is only
    // loaded when the output register is empty or its symbol transfers
    always_comb begin
        w_fsm_nxt        = r_fsm;
        w_state_nxt      = r_state;
        w_step_nxt       = r_step;
        w_byte_nxt       = r_byte;
        w_sym_nxt        = r_sym;
        w_sym_valid_nxt  = r_sym_valid;
        w_flush_done_nxt = 1'b0;
        case (r_fsm)
            ST_IDLE: begin
                if (w_byte_xfer) begin
                    w_byte_nxt      = i_data;
                    w_step_nxt      = {STEP_W{1'b0}};
                    w_fsm_nxt       = ST_ENCODE;
                    w_sym_nxt       = w_sym;
                    w_sym_valid_nxt = 1'b1;
                    w_state_nxt     = w_state_shift;
                end else if (i_flush) begin
                    w_step_nxt      = {STEP_W{1'b0}};
                    w_fsm_nxt       = ST_FLUSH;
                    w_sym_nxt       = w_sym;
                    w_sym_valid_nxt = 1'b1;
                    w_state_nxt     = w_state_shift;
                end else begin
                    w_fsm_nxt = ST_IDLE;
                end
            end
            ST_ENCODE: begin
                if (w_sym_xfer) begin
                    if (r_step == LAST_DATA_STEP) begin
                        w_fsm_nxt       = ST_IDLE;
                        w_sym_nxt       = {SYM_W{1'b0}};
                        w_sym_valid_nxt = 1'b0;
                    end else begin
                        w_step_nxt      = r_step + 2'd1;
                        w_sym_nxt       = w_sym;
                        w_sym_valid_nxt = 1'b1;
                        w_state_nxt     = w_state_shift;
                    end
                end else begin
                    w_fsm_nxt = ST_ENCODE;
                end
            end
            ST_FLUSH: begin
                if (w_sym_xfer) begin
                    if (r_step == LAST_TAIL_STEP) begin
                        w_fsm_nxt        = ST_IDLE;
                        w_sym_nxt        = {SYM_W{1'b0}};
                        w_sym_valid_nxt  = 1'b0;
                        w_flush_done_nxt = 1'b1;
                    end else begin
                        w_step_nxt      = r_step + 2'd1;
                        w_sym_nxt       = w_sym;
                        w_sym_valid_nxt = 1'b1;
                        w_state_nxt     = w_state_shift;
                    end
                end else begin
                    w_fsm_nxt = ST_FLUSH;
                end
            end
            default: begin
                w_fsm_nxt       = ST_IDLE;
                w_sym_nxt       = {SYM_W{1'b0}};
                w_sym_valid_nxt = 1'b0;
            end
        endcase
        w_data_ready_nxt = (w_fsm_nxt == ST_IDLE);
        w_busy_nxt       = (w_fsm_nxt != ST_IDLE);
    end

    // State and output registers; reset aborts any byte or flush in flight
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_fsm        <= ST_IDLE;
            r_state      <= {STATE_W{1'b0}};
            r_step       <= {STEP_W{1'b0}};
            r_byte       <= 8'h00;
            r_sym        <= {SYM_W{1'b0}};
            r_sym_valid  <= 1'b0;
            r_data_ready <= 1'b0;
            r_busy       <= 1'b0;
            r_flush_done <= 1'b0;
        end else begin
            r_fsm        <= w_fsm_nxt;
            r_state      <= w_state_nxt;
            r_step       <= w_step_nxt;
            r_byte       <= w_byte_nxt;
            r_sym        <= w_sym_nxt;
            r_sym_valid  <= w_sym_valid_nxt;
            r_data_ready <= w_data_ready_nxt;
            r_busy       <= w_busy_nxt;
            r_flush_done <= w_flush_done_nxt;
        end
    end

    assign o_sym        = r_sym;
    assign o_sym_valid  = r_sym_valid;
    assign o_data_ready = r_data_ready;
    assign o_state      = r_state;
    assign o_busy       = r_busy;
    assign o_flush_done = r_flush_done;

endmodule

// File: tb/tb_conv_encoder.sv
// Scoreboard bench for conv_encoder: stimulus pushes hand-computed
// {symbol, state} expectations, a negedge monitor pops them on every
// symbol transfer and also checks hold-under-backpressure and flush_done.
module tb_conv_encoder;

    logic       clk;
    logic       rst;
    logic [7:0] i_data;
    logic       i_data_valid;
    logic       o_data_ready;
    logic       i_flush;
    logic [3:0] o_sym;
    logic       o_sym_valid;
    logic       i_sym_ready;
    logic [7:0] o_state;
    logic       o_busy;
    logic       o_flush_done;

    conv_encoder dut (
        .clk          (clk),
        .rst          (rst),
        .i_data       (i_data),
        .i_data_valid (i_data_valid),
        .o_data_ready (o_data_ready),
        .i_flush      (i_flush),
        .o_sym        (o_sym),
        .o_sym_valid  (o_sym_valid),
        .i_sym_ready  (i_sym_ready),
        .o_state      (o_state),
        .o_busy       (o_busy),
        .o_flush_done (o_flush_done)
    );

    typedef struct packed {
        logic [3:0] sym;
        logic [7:0] st;
        logic       last_tail;
    } exp_t;

    exp_t q[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    bit   pend_done  = 1'b0;
    bit   prev_stall = 1'b0;
    logic [3:0] prev_sym;
    logic [7:0] prev_state;
    logic [3:0] rdy_pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push(input logic [3:0] sym, input logic [7:0] st, input logic last_tail);
        exp_t e;
        e.sym = sym; e.st = st; e.last_tail = last_tail;
        q.push_back(e);
    endtask

    // Monitor: compare every transferred symbol against the scoreboard
    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            pend_done  = 1'b0;
            prev_stall = 1'b0;
        end else begin
            if (pend_done) begin
                check("flush_done_pulse", {31'd0, o_flush_done}, 32'd1);
                pend_done = 1'b0;
            end else if (o_flush_done) begin
                check("flush_done_spurious", {31'd0, o_flush_done}, 32'd0);
            end
            if (prev_stall && o_sym_valid) begin
                check("hold_sym", {28'd0, o_sym}, {28'd0, prev_sym});
                check("hold_state", {24'd0, o_state}, {24'd0, prev_state});
            end
            if (o_sym_valid && i_sym_ready) begin
                if (q.size() == 0) begin
                    check("unexpected_sym", 32'd1, 32'd0);
                end else begin
                    e = q.pop_front();
                    check("sym", {28'd0, o_sym}, {28'd0, e.sym});
                    check("state", {24'd0, o_state}, {24'd0, e.st});
                    if (e.last_tail) pend_done = 1'b1;
                end
            end
            prev_stall = o_sym_valid && !i_sym_ready;
            prev_sym   = o_sym;
            prev_state = o_state;
        end
    end

    task automatic send_byte(input logic [7:0] b);
        bit acc;
        acc = 1'b0;
        i_data = b;
        i_data_valid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            acc = o_data_ready;
            @(posedge clk);
            #1;
            if (acc) break;
        end
        i_data_valid = 1'b0;
        if (!acc) check("byte_accept_timeout", 32'd0, 32'd1);
    endtask

    task automatic do_flush();
        @(posedge clk);
        #1 i_flush = 1'b1;
        @(posedge clk);
        #1 i_flush = 1'b0;
        check("busy_in_flush", {31'd0, o_busy}, 32'd1);
    endtask

    task automatic drain(input int budget, input bit toggle);
        bit done;
        done = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(posedge clk);
            #1;
            if (toggle) i_sym_ready = rdy_pat[i % 4];
            if (q.size() == 0) begin
                done = 1'b1;
                break;
            end
        end
        i_sym_ready = 1'b1;
        if (!done) check("drain_timeout", 32'd0, 32'd1);
        repeat (2) @(posedge clk);
        #1;
        check("idle_valid", {31'd0, o_sym_valid}, 32'd0);
        check("idle_busy", {31'd0, o_busy}, 32'd0);
        check("idle_ready", {31'd0, o_data_ready}, 32'd1);
    endtask

    task automatic push_byte01();
        push(4'b1010, 8'h02, 1'b0);
        push(4'b1100, 8'h08, 1'b0);
        push(4'b1100, 8'h20, 1'b0);
        push(4'b0100, 8'h80, 1'b0);
    endtask

    task automatic push_tail_from80();
        push(4'b1100, 8'h00, 1'b0);
        push(4'b0000, 8'h00, 1'b0);
        push(4'b0000, 8'h00, 1'b0);
        push(4'b0000, 8'h00, 1'b1);
    endtask

    initial begin
        int  acc_n, rdy_between, rdy_low;
        bit  acc_now;
        rst = 1'b0;
        i_data = 8'h00;
        i_data_valid = 1'b0;
        i_flush = 1'b0;
        i_sym_ready = 1'b1;

        // Reset values
        repeat (3) @(posedge clk);
        #1;
        check("rst_sym", {28'd0, o_sym}, 32'd0);
        check("rst_valid", {31'd0, o_sym_valid}, 32'd0);
        check("rst_ready", {31'd0, o_data_ready}, 32'd0);
        check("rst_busy", {31'd0, o_busy}, 32'd0);
        check("rst_state", {24'd0, o_state}, 32'd0);
        check("rst_done", {31'd0, o_flush_done}, 32'd0);
        @(negedge clk) rst = 1'b1;
        @(posedge clk);
        #1;
        check("post_rst_ready", {31'd0, o_data_ready}, 32'd1);

        // Byte 0x00 from state 0
        for (int i = 0; i < 4; i++) push(4'b0000, 8'h00, 1'b0);
        send_byte(8'h00);
        check("busy_in_encode", {31'd0, o_busy}, 32'd1);
        drain(40, 1'b0);

        // Byte 0x01 then a zero-tail flush
        push_byte01();
        send_byte(8'h01);
        drain(40, 1'b0);
        push_tail_from80();
        do_flush();
        drain(40, 1'b0);

        // Byte 0x01 under backpressure, then flush back to 0
        push_byte01();
        send_byte(8'h01);
        drain(60, 1'b1);
        push_tail_from80();
        do_flush();
        drain(40, 1'b0);

        // Back-to-back 0xFF then 0x00 with valid held high
        push(4'b0111, 8'h03, 1'b0);
        push(4'b1111, 8'h0F, 1'b0);
        push(4'b0011, 8'h3F, 1'b0);
        push(4'b1111, 8'hFF, 1'b0);
        push(4'b1100, 8'hFC, 1'b0);
        push(4'b0100, 8'hF0, 1'b0);
        push(4'b1000, 8'hC0, 1'b0);
        push(4'b0100, 8'h00, 1'b0);
        acc_n = 0; rdy_between = 0; rdy_low = 0;
        i_data = 8'hFF;
        i_data_valid = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            acc_now = o_data_ready;
            if (acc_n == 1) begin
                if (o_data_ready) rdy_between++;
                else rdy_low++;
            end
            @(posedge clk);
            #1;
            if (acc_now) begin
                acc_n++;
                if (acc_n == 1) i_data = 8'h00;
                if (acc_n == 2) break;
            end
        end
        i_data_valid = 1'b0;
        check("b2b_accepts", acc_n, 32'd2);
        check("b2b_ready_high", rdy_between, 32'd1);
        check("b2b_ready_low", rdy_low, 32'd4);
        drain(40, 1'b0);

        // Reset asserted while step 2 of byte 0x01 is presented
        push(4'b1010, 8'h02, 1'b0);
        push(4'b1100, 8'h08, 1'b0);
        send_byte(8'h01);
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            if (q.size() == 0) break;
        end
        #1;
        check("pre_rst_state", {24'd0, o_state}, 32'h20);
        rst = 1'b0;
        #1;
        check("mid_rst_sym", {28'd0, o_sym}, 32'd0);
        check("mid_rst_valid", {31'd0, o_sym_valid}, 32'd0);
        check("mid_rst_ready", {31'd0, o_data_ready}, 32'd0);
        check("mid_rst_busy", {31'd0, o_busy}, 32'd0);
        check("mid_rst_state", {24'd0, o_state}, 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk) rst = 1'b1;
        @(posedge clk);
        #1;
        check("rerst_ready", {31'd0, o_data_ready}, 32'd1);
        check("rerst_state", {24'd0, o_state}, 32'd0);
        for (int i = 0; i < 4; i++) push(4'b0000, 8'h00, 1'b0);
        send_byte(8'h00);
        drain(40, 1'b0);

        check("scoreboard_empty", q.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
